// File: rtl/mrd_mem_stat_gen.sv
// Per-memory sequencer for one ping-pong buffer: sink, per-stage read/write
// passes, then source. Generates the status flags consumed by the top control FSM.
module mrd_mem_stat_gen #(
    parameter int unsigned MEM_ID  = 0,
    parameter int unsigned MAX_PTS = 1200,
    parameter int unsigned MIN_PTS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_in,
    input  logic [2:0]  NumOfFactors,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [11:0] in_dftpts,
    input  logic        wr_valid,
    input  logic        out_ready,
    output logic        in_ready,
    output logic        sink_sop,
    output logic [11:0] dftpts,
    output logic        sink_ongoing,
    output logic        rd_ongoing,
    output logic        wr_ongoing,
    output logic        source_ongoing,
    output logic        source_start,
    output logic        source_end,
    output logic [2:0]  current_stage,
    output logic [11:0] addr,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_SINK, S_RD, S_WR, S_SRC} state_t;

    localparam logic [11:0] LP_MIN = 12'(MIN_PTS);
    localparam logic [11:0] LP_MAX = 12'(MAX_PTS);
    localparam logic        LP_SEL = 1'(MEM_ID);

    state_t      r_state, w_state_nx;
    logic [11:0] r_addr, w_addr_nx;
    logic [11:0] r_dftpts, w_dftpts_nx;
    logic [2:0]  r_stage, w_stage_nx;
    logic [2:0]  r_nf, w_nf_nx;
    logic        w_sink_sop, w_frame_err, w_src_start, w_src_end;
    logic        w_last, w_len_ok, w_sel;

    assign w_last   = (r_addr == r_dftpts - 12'd1);
    assign w_len_ok = (in_dftpts >= LP_MIN) && (in_dftpts <= LP_MAX);
    assign w_sel    = (sw_in == LP_SEL);

    assign dftpts        = r_dftpts;
    assign addr          = r_addr;
    assign current_stage = r_stage;

    always_comb begin
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_dftpts_nx = r_dftpts;
        w_stage_nx  = r_stage;
        w_nf_nx     = r_nf;
        w_sink_sop  = 1'b0;
        w_frame_err = 1'b0;
        w_src_start = 1'b0;
        w_src_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_sop && in_ready) begin
                    if (w_len_ok) begin
                        // the sop beat itself is sample 0
                        w_dftpts_nx = in_dftpts;
                        w_nf_nx     = (NumOfFactors == 3'd0) ? 3'd1 : NumOfFactors;
                        w_sink_sop  = 1'b1;
                        w_addr_nx   = 12'd1;
                        w_state_nx  = S_SINK;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            S_SINK: begin
                if (in_valid) begin
                    if (w_last) begin
                        w_state_nx = S_RD;
                        w_addr_nx  = '0;
                        w_stage_nx = '0;
                    end else if (in_eop) begin
                        w_frame_err = 1'b1;
                        w_state_nx  = S_IDLE;
                        w_addr_nx   = '0;
                    end else begin
                        w_addr_nx = r_addr + 12'd1;
                    end
                end
            end
            S_RD: begin
                if (w_last) begin
                    w_state_nx = S_WR;
                    w_addr_nx  = '0;
                end else begin
                    w_addr_nx = r_addr + 12'd1;
                end
            end
            S_WR: begin
                if (wr_valid) begin
                    if (w_last) begin
                        w_addr_nx = '0;
                        if (r_stage == r_nf - 3'd1) begin
                            w_state_nx  = S_SRC;
                            w_src_start = 1'b1;
                        end else begin
                            w_stage_nx = r_stage + 3'd1;
                            w_state_nx = S_RD;
                        end
                    end else begin
                        w_addr_nx = r_addr + 12'd1;
                    end
                end
            end
            S_SRC: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_src_end  = 1'b1;
                        w_state_nx = S_IDLE;
                        w_addr_nx  = '0;
                    end else begin
                        w_addr_nx = r_addr + 12'd1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status outputs decode the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_dftpts       <= '0;
            r_stage        <= '0;
            r_nf           <= '0;
            in_ready       <= 1'b0;
            sink_sop       <= 1'b0;
            frame_err      <= 1'b0;
            source_start   <= 1'b0;
            source_end     <= 1'b0;
            sink_ongoing   <= 1'b0;
            rd_ongoing     <= 1'b0;
            wr_ongoing     <= 1'b0;
            source_ongoing <= 1'b0;
            out_valid      <= 1'b0;
            out_sop        <= 1'b0;
            out_eop        <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_addr         <= w_addr_nx;
            r_dftpts       <= w_dftpts_nx;
            r_stage        <= w_stage_nx;
            r_nf           <= w_nf_nx;
            in_ready       <= (w_state_nx == S_SINK) || ((w_state_nx == S_IDLE) && w_sel);
            sink_sop       <= w_sink_sop;
            frame_err      <= w_frame_err;
            source_start   <= w_src_start;
            source_end     <= w_src_end;
            sink_ongoing   <= (w_state_nx == S_SINK);
            rd_ongoing     <= (w_state_nx == S_RD);
            wr_ongoing     <= (w_state_nx == S_WR);
            source_ongoing <= (w_state_nx == S_SRC);
            out_valid      <= (w_state_nx == S_SRC);
            out_sop        <= (w_state_nx == S_SRC) && (w_addr_nx == 12'd0);
            out_eop        <= (w_state_nx == S_SRC) && (w_addr_nx == w_dftpts_nx - 12'd1);
        end
    end

endmodule

// File: tb/tb_mrd_mem_stat_gen.sv
// Randomized bench for mrd_mem_stat_gen against a phase/counter reference model.
module tb_mrd_mem_stat_gen;

    localparam int MEM_ID = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_in;
    logic [2:0]  NumOfFactors;
    logic        in_valid, in_sop, in_eop;
    logic [11:0] in_dftpts;
    logic        wr_valid, out_ready;
    logic        in_ready, sink_sop;
    logic [11:0] dftpts;
    logic        sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing;
    logic        source_start, source_end;
    logic [2:0]  current_stage;
    logic [11:0] addr;
    logic        out_valid, out_sop, out_eop, frame_err;

    mrd_mem_stat_gen #(.MEM_ID(MEM_ID), .MAX_PTS(1200), .MIN_PTS(12)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .NumOfFactors(NumOfFactors),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_dftpts(in_dftpts),
        .wr_valid(wr_valid), .out_ready(out_ready), .in_ready(in_ready),
        .sink_sop(sink_sop), .dftpts(dftpts), .sink_ongoing(sink_ongoing),
        .rd_ongoing(rd_ongoing), .wr_ongoing(wr_ongoing), .source_ongoing(source_ongoing),
        .source_start(source_start), .source_end(source_end),
        .current_stage(current_stage), .addr(addr), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sop, n_err, n_end, n_rd, n_xfer;

    // Reference model: phase 0 idle, 1 sink, 2 read pass, 3 write pass, 4 source.
    int m_ph, m_idx, m_pts, m_stg, m_nf;
    bit m_rdy, m_sop, m_err, m_ss, m_se;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_dut();
        return {25'd0, in_ready, sink_sop, dftpts, sink_ongoing, rd_ongoing, wr_ongoing,
                source_ongoing, source_start, source_end, current_stage, addr,
                out_valid, out_sop, out_eop, frame_err};
    endfunction

    function automatic logic [63:0] pack_model();
        return {25'd0, m_rdy, m_sop, 12'(m_pts), m_ph == 1, m_ph == 2, m_ph == 3,
                m_ph == 4, m_ss, m_se, 3'(m_stg), 12'(m_idx),
                m_ph == 4, (m_ph == 4) && (m_idx == 0), (m_ph == 4) && (m_idx == m_pts - 1), m_err};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_idx = 0; m_pts = 0; m_stg = 0; m_nf = 0;
        m_rdy = 0; m_sop = 0; m_err = 0; m_ss = 0; m_se = 0;
    endtask

    task automatic model_edge();
        bit rdy_now;
        rdy_now = m_rdy;
        m_sop = 0; m_err = 0; m_ss = 0; m_se = 0;
        case (m_ph)
            0: if (in_valid && in_sop && rdy_now) begin
                if (int'(in_dftpts) >= 12 && int'(in_dftpts) <= 1200) begin
                    m_pts = int'(in_dftpts);
                    m_nf  = (NumOfFactors == 0) ? 1 : int'(NumOfFactors);
                    m_sop = 1; m_idx = 1; m_ph = 1;
                end else m_err = 1;
            end
            1: if (in_valid) begin
                if (m_idx == m_pts - 1) begin m_ph = 2; m_idx = 0; m_stg = 0; end
                else if (in_eop) begin m_err = 1; m_ph = 0; m_idx = 0; end
                else m_idx++;
            end
            2: if (m_idx == m_pts - 1) begin m_ph = 3; m_idx = 0; end else m_idx++;
            3: if (wr_valid) begin
                if (m_idx == m_pts - 1) begin
                    m_idx = 0;
                    if (m_stg == m_nf - 1) begin m_ph = 4; m_ss = 1; end
                    else begin m_stg++; m_ph = 2; end
                end else m_idx++;
            end
            4: if (out_ready) begin
                if (m_idx == m_pts - 1) begin m_se = 1; m_ph = 0; m_idx = 0; end
                else m_idx++;
            end
            default: m_ph = 0;
        endcase
        m_rdy = (m_ph == 1) || (m_ph == 0 && int'(sw_in) == MEM_ID);
    endtask

    task automatic clr_cnt();
        n_sop = 0; n_err = 0; n_end = 0; n_rd = 0; n_xfer = 0;
    endtask

    task automatic cyc();
        if (out_valid && out_ready) n_xfer++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (sink_sop) n_sop++;
        if (frame_err) n_err++;
        if (source_end) n_end++;
        if (rd_ongoing) n_rd++;
        check_val("outs", pack_dut(), pack_model());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sop = 0;
            in_eop = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 0; in_eop = 0;
    endtask

    task automatic send_frame(input int len, input int nbeats, input int eop_beat);
        int sent;
        int guard;
        bit acc;
        sent = 0;
        guard = 0;
        while (sent < nbeats && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sop    = in_valid ? (sent == 0 || $urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
            in_eop    = in_valid ? (sent == eop_beat) : 1'($urandom_range(0, 1));
            in_dftpts = 12'(len);
            acc = in_valid && m_rdy;
            cyc();
            guard++;
            if (acc) sent++;
            if (sent > 0 && m_ph != 1) break;
        end
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic drain(input int wmode, input int rmode, input bit jitter);
        int guard;
        int k;
        guard = 0;
        k = 0;
        while (m_ph != 0 && guard < 40000) begin
            wr_valid = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (k % 4 == 0) || (k % 4 == 3);
            endcase
            if (m_ph == 4) k++;
            if (jitter) begin
                NumOfFactors = 3'($urandom_range(0, 6));
                sw_in = 1'($urandom_range(0, 1));
            end
            cyc();
            guard++;
        end
        check_val("drain_idle", {60'd0, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing}, 64'd0);
        sw_in = 1'(MEM_ID);
        out_ready = 0; wr_valid = 0;
        cyc();
    endtask

    initial begin
        int len, eb, g;
        rst = 1; sw_in = 1'(MEM_ID); NumOfFactors = 0;
        in_valid = 0; in_sop = 0; in_eop = 0; in_dftpts = 0;
        wr_valid = 0; out_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_state", pack_dut(), 64'd0);
        rst = 0;
        idle(3);

        // Full-size frame, five stages, no back-pressure
        clr_cnt();
        NumOfFactors = 5;
        send_frame(1200, 1200, 1199);
        drain(0, 0, 0);
        check_val("t1_sink_sop", 64'(n_sop), 64'd1);
        check_val("t1_rd_cycles", 64'(n_rd), 64'd6000);
        check_val("t1_xfers", 64'(n_xfer), 64'd1200);
        check_val("t1_src_end", 64'(n_end), 64'd1);
        check_val("t1_dftpts", 64'(dftpts), 64'd1200);

        // Other memory selected: sop must be refused
        clr_cnt();
        sw_in = ~1'(MEM_ID);
        idle(2);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1; in_sop = 1; in_dftpts = 12'd1200;
            cyc();
        end
        in_valid = 0; in_sop = 0;
        check_val("t2_no_sop", 64'(n_sop), 64'd0);
        check_val("t2_in_ready", 64'(in_ready), 64'd0);
        sw_in = 1'(MEM_ID);
        idle(2);
        NumOfFactors = 2;
        send_frame(12, 12, 11);
        drain(1, 1, 0);
        check_val("t2_sop_after", 64'(n_sop), 64'd1);

        // Illegal lengths
        clr_cnt();
        send_frame(2000, 1, 0);
        idle(2);
        send_frame(0, 1, 0);
        idle(2);
        send_frame(11, 1, 0);
        send_frame(1201, 1, 0);
        check_val("t3_frame_err", 64'(n_err), 64'd4);
        check_val("t3_dftpts_hold", 64'(dftpts), 64'd12);

        // Premature eop, then a normal frame
        clr_cnt();
        NumOfFactors = 1;
        send_frame(300, 300, 100);
        check_val("t4_frame_err", 64'(n_err), 64'd1);
        check_val("t4_idle", {60'd0, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing}, 64'd0);
        idle(2);
        NumOfFactors = 3;
        send_frame(20, 20, 19);
        drain(1, 0, 1);
        check_val("t4_recover_end", 64'(n_end), 64'd1);

        // Source back-pressure pattern 1,0,0,1
        idle(2);
        clr_cnt();
        NumOfFactors = 1;
        send_frame(12, 12, 11);
        drain(0, 2, 0);
        check_val("t5_xfers", 64'(n_xfer), 64'd12);
        check_val("t5_src_end", 64'(n_end), 64'd1);

        // Asynchronous reset in stage 2 write pass
        idle(2);
        NumOfFactors = 5;
        send_frame(12, 12, 11);
        g = 0;
        while (!(m_ph == 3 && m_stg == 2 && m_idx == 5) && g < 2000) begin
            wr_valid = 1;
            cyc();
            g++;
        end
        check_val("t6_in_wr2", {60'd0, wr_ongoing, current_stage}, {60'd0, 1'b1, 3'd2});
        #2 rst = 1;
        #1 check_val("t6_async_rst", pack_dut(), 64'd0);
        model_reset();
        @(negedge clk);
        check_val("t6_rst_hold", pack_dut(), 64'd0);
        rst = 0;
        idle(2);
        clr_cnt();
        NumOfFactors = 3;
        send_frame(12, 12, 11);
        drain(1, 1, 0);
        check_val("t6_after_end", 64'(n_end), 64'd1);

        // Random frames: lengths, stage counts, gaps and back-pressure
        for (int f = 0; f < 24; f++) begin
            idle($urandom_range(1, 4));
            NumOfFactors = 3'($urandom_range(0, 6));
            case ($urandom_range(0, 9))
                0: len = 11;
                1: len = 1201;
                default: len = $urandom_range(12, 40);
            endcase
            case ($urandom_range(0, 4))
                0: eb = $urandom_range(1, 9);
                1: eb = len;
                default: eb = len - 1;
            endcase
            send_frame(len, len, eb);
            if (m_ph != 0) drain(1, 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mrd_mem_stat_gen.md
Name: mrd_mem_stat_gen

Overview:
Per-memory sequencer on the mrd_mem_top side of the status/control link.
- Consumes the stage configuration from the top control FSM (NumOfFactors) and the input-select switch.
- Steps one ping-pong memory through sink, per-stage read/write and source phases.
- Generates the status set the top FSM consumes: sink_sop, dftpts, the four *_ongoing flags, source_start and source_end.
- Two instances are used, one per memory, with MEM_ID 0 and 1.

Parameters:
MEM_ID, 0, which sw_in value selects this memory for input (0 or 1).
MAX_PTS, 1200, largest legal DFT length.
MIN_PTS, 12, smallest legal DFT length.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous active-high reset.
sw_in  in  1  input switch from top FSM; this block accepts sink only when sw_in==MEM_ID.
NumOfFactors  in  3  number of DFT stages (1..6).
in_valid  in  1  sink sample valid.
in_sop  in  1  first sample of frame; qualified by in_valid.
in_eop  in  1  last sample of frame; qualified by in_valid.
in_dftpts  in  12  frame length; sampled with in_sop.
wr_valid  in  1  stage-result beat returning from the butterfly datapath.
out_ready  in  1  downstream accepts a source beat.
in_ready  out  1  sink may accept a beat.
sink_sop  out  1  one-cycle pulse when a legal frame starts.
dftpts  out  12  latched frame length.
sink_ongoing  out  1  high in SINK.
rd_ongoing  out  1  high in RD.
wr_ongoing  out  1  high in WR.
source_ongoing  out  1  high in SRC.
source_start  out  1  one-cycle pulse on entry to SRC.
source_end  out  1  one-cycle pulse on the last accepted source beat.
current_stage  out  3  stage index 0..NumOfFactors-1.
addr  out  12  sample index within the current phase.
out_valid  out  1  source beat valid.
out_sop  out  1  first source beat.
out_eop  out  1  last source beat.
frame_err  out  1  one-cycle pulse on an illegal length or premature eop.

Behaviour:
- Reset: every output is 0. State is IDLE, counters and dftpts are 0, and nf_lat is 0.

State machine (IDLE, SINK, RD, WR, SRC):
- IDLE:
  - in_ready = (sw_in==MEM_ID).
  - On in_valid & in_sop & in_ready, check the length.
  - Legal length (MIN_PTS<=in_dftpts<=MAX_PTS):
    - Latch dftpts, latch NumOfFactors into nf_lat, and pulse sink_sop the same cycle.
    - That beat is sample 0; go to SINK with addr=1.
    - If dftpts==1 the frame is not legal, so the single-beat sop+eop case cannot occur.
  - Illegal length: pulse frame_err and stay IDLE.
  - in_valid without in_sop in IDLE is ignored.
- SINK:
  - in_ready=1. Each in_valid increments addr.
  - The beat with addr==dftpts-1 moves the block to RD with addr=0, current_stage=0.
  - That final beat is expected to carry in_eop, but in_eop is not required on it.
  - in_eop earlier than addr==dftpts-1: pulse frame_err, return to IDLE, no sink_sop retraction.
  - A second in_sop mid-frame is ignored as a data beat.
- RD:
  - in_ready=0. addr increments every cycle 0..dftpts-1, then go to WR with addr=0.
- WR:
  - Each wr_valid increments addr.
  - At addr==dftpts-1 with wr_valid:
    - If current_stage==nf_lat-1, go to SRC, pulse source_start, addr=0.
    - Otherwise current_stage+1 and return to RD.
  - No timeout.
- SRC:
  - out_valid=1.
  - A beat transfers when out_ready=1; addr increments on each transfer.
  - out_sop = (addr==0).
  - out_eop = (addr==dftpts-1).
  - On the transfer with out_eop: pulse source_end, go to IDLE, out_valid drops the next cycle.
  - out_ready low holds addr, out_valid and the flags stable.

Status and general rules:
- *_ongoing flags are registered decodes of state and match the state in the same cycle.
- Configuration sampling: NumOfFactors changes after sink_sop do not affect the frame; NumOfFactors==0 is treated as 1.
- Input select: sw_in changing while not in IDLE has no effect; the frame completes.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0; the frame is discarded.
- Pulse exclusivity: source_start and source_end never assert in the same cycle. sink_sop never asserts while source_ongoing of this instance is 1.

Test Plan:
1. MEM_ID=0, sw_in=0, NumOfFactors=5, 1200-beat frame with sop/eop, wr_valid always 1, out_ready=1.
   -> sink_sop 1 cycle, dftpts=1200, 5 RD/WR pairs of 1200 cycles each, source_start, 1200 out beats, source_end on the last.
2. Same frame with sw_in=1.
   -> in_ready=0 and no sink_sop. After sw_in=0, the next sop is accepted.
3. in_dftpts=2000, then in_dftpts=0.
   -> frame_err pulses twice, state stays IDLE, dftpts unchanged.
4. 300-pt frame with in_eop on beat 100.
   -> frame_err at beat 100, IDLE; a following legal frame runs normally.
5. SRC phase with out_ready toggling 1,0,0,1 on 12-pt frame.
   -> addr holds during stalls, exactly 12 transfers, out_eop/source_end only on the 12th.
6. Assert rst during stage 2 WR.
   -> all outputs 0 immediately; next 12-pt frame completes with current_stage starting at 0.
